// File: rtl/shared_reg_arbiter.sv
// Purpose : round-robin arbiter granting NUM_REQ writers one shared register, with optional locked bursts.
// Latency : request sampled -> registered grant/en_o/d_o after 1 edge; q_o updates 1 edge after that.
// Backpr. : requesters hold req_i until they see gnt_o; losers and non-owners during a lock simply wait.
// Ports   : clk_i/rst_i (sync, active-high); req_i/lock_i/data_i per-requester inputs;
//           gnt_o one-hot grant, en_o/d_o register write strobe and data, q_o register contents,
//           owner_o last granted index, lock_err_o single-cycle lock timeout pulse.
module shared_reg_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int LOCK_MAX = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ-1:0]          lock_i,
   input  logic [NUM_REQ*DATA_W-1:0]   data_i,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic                        en_o,
   output logic [DATA_W-1:0]           d_o,
   output logic [DATA_W-1:0]           q_o,
   output logic [$clog2(NUM_REQ)-1:0]  owner_o,
   output logic                        lock_err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Counter value at which the next LOCKED edge is the timeout edge.
   localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

   logic [0:0]         state;
   logic [IDX_W-1:0]   ptr;
   logic [7:0]         lock_cnt;

   logic [NUM_REQ-1:0] avail;
   logic               found;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   ptr_next;
   logic [DATA_W-1:0]  win_data;
   logic [DATA_W-1:0]  own_data;
   logic [NUM_REQ-1:0] win_onehot;
   logic [NUM_REQ-1:0] own_onehot;

   // A request whose grant is on the outputs right now has already been served;
   // masking it stops a held request from being granted twice back to back.
   assign avail = req_i & ~gnt_o;

   // Round-robin scan starting at ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      win   = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && avail[j]) begin
            found = 1'b1;
            win   = IDX_W'(j);
         end
      end
   end

   assign ptr_next   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
   assign win_data   = data_i[int'(win) * DATA_W +: DATA_W];
   assign own_data   = data_i[int'(owner_o) * DATA_W +: DATA_W];
   assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
   assign own_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         lock_cnt   <= '0;
         gnt_o      <= '0;
         en_o       <= 1'b0;
         d_o        <= '0;
         q_o        <= '0;
         owner_o    <= '0;
         lock_err_o <= 1'b0;
      end else begin
         lock_err_o <= 1'b0;
         gnt_o      <= '0;
         en_o       <= 1'b0;
         if (en_o) q_o <= d_o;

         case (state)
            ST_IDLE: begin
               if (found) begin
                  gnt_o   <= win_onehot;
                  en_o    <= 1'b1;
                  d_o     <= win_data;
                  owner_o <= win;
                  ptr     <= ptr_next;
                  if (lock_i[win]) begin
                     state    <= ST_LOCKED;
                     lock_cnt <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               // Timeout wins over both a release and an owner request.
               if (lock_cnt == CNT_LAST) begin
                  state      <= ST_IDLE;
                  lock_cnt   <= '0;
                  lock_err_o <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
                  if (!lock_i[owner_o]) begin
                     state <= ST_IDLE;
                  end else if (req_i[owner_o]) begin
                     // ptr already points past the owner from the lock-entry grant.
                     gnt_o <= own_onehot;
                     en_o  <= 1'b1;
                     d_o   <= own_data;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
